// File: rtl/encoder_led_ctrl_if.sv
// Pin-side bundle of the encoder/LED controller: raw encoder pins in, brightness
// state, event pulses and PWM LED out.
interface encoder_led_ctrl_if;
  logic       x_clk;
  logic       x_dt;
  logic       x_sw;
  logic [7:0] value;
  logic       step_up;
  logic       step_dn;
  logic       sw_press;
  logic       enable;
  logic       LED;

  modport master (
    output x_clk, x_dt, x_sw,
    input  value, step_up, step_dn, sw_press, enable, LED
  );

  modport slave (
    input  x_clk, x_dt, x_sw,
    output value, step_up, step_dn, sw_press, enable, LED
  );
endinterface

// File: rtl/encoder_led_ctrl.sv
// Rotary-encoder brightness controller: sync + debounce, quadrature decode, press toggle, 8-bit PWM.
// Define ENC_WRAP_EN to make the brightness wrap modulo 256 instead of saturating.
module encoder_led_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned STEP            = 8,
  parameter int unsigned INIT_VAL        = 128
) (
  input  logic              clk50m,
  input  logic              rst_n,
  encoder_led_ctrl_if.slave bus
);
  localparam int unsigned NPIN  = 3;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned XW    = VAL_W + 1;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [XW-1:0]    STEP_X   = XW'(STEP);
  localparam logic [XW-1:0]    MAX_X    = XW'(255);

  typedef enum logic [2:0] {
    S_REST, S_CW1, S_CW2, S_CW3, S_CCW1, S_CCW2, S_CCW3
  } state_t;

  logic [NPIN-1:0]  w_pins;
  logic [NPIN-1:0]  r_sync1;
  logic [NPIN-1:0]  r_sync2;
  logic [NPIN-1:0]  r_filt;
  logic [CNT_W-1:0] r_cnt [NPIN];

  logic             w_sw_fall;
  logic [1:0]       w_ab;
  logic [XW-1:0]    w_sum;
  logic [XW-1:0]    w_dif;
  logic [VAL_W-1:0] w_val_up;
  logic [VAL_W-1:0] w_val_dn;

  state_t           r_state;
  logic [VAL_W-1:0] r_value;
  logic             r_step_up;
  logic             r_step_dn;
  logic             r_sw_press;
  logic             r_enable;
  logic [VAL_W-1:0] r_pwm_cnt;
  logic             r_led;

  // bit 0 = encoder A, bit 1 = encoder B, bit 2 = button
  assign w_pins = {bus.x_sw, bus.x_dt, bus.x_clk};

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_filt  <= '1;
      for (int i = 0; i < int'(NPIN); i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
      for (int i = 0; i < int'(NPIN); i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press is flagged on the same edge the filtered button level falls.
  assign w_sw_fall = r_filt[2] & ~r_sync2[2] & (r_cnt[2] == CNT_LAST);
  assign w_ab      = {r_filt[0], r_filt[1]};
  assign w_sum     = {1'b0, r_value} + STEP_X;
  assign w_dif     = {1'b0, r_value} - STEP_X;

`ifdef ENC_WRAP_EN
  assign w_val_up = w_sum[VAL_W-1:0];
  assign w_val_dn = w_dif[VAL_W-1:0];
`else
  assign w_val_up = (w_sum > MAX_X) ? '1 : w_sum[VAL_W-1:0];
  assign w_val_dn = w_dif[VAL_W]    ? '0 : w_dif[VAL_W-1:0];
`endif

  // Unlisted patterns (double-bit jumps) leave the state unchanged.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_REST;
      r_value   <= VAL_W'(INIT_VAL);
      r_step_up <= 1'b0;
      r_step_dn <= 1'b0;
    end else begin
      r_step_up <= 1'b0;
      r_step_dn <= 1'b0;
      case (r_state)
        S_REST: begin
          if      (w_ab == 2'b01) r_state <= S_CW1;
          else if (w_ab == 2'b10) r_state <= S_CCW1;
        end
        S_CW1: begin
          if      (w_ab == 2'b00) r_state <= S_CW2;
          else if (w_ab == 2'b11) r_state <= S_REST;
        end
        S_CW2: begin
          if      (w_ab == 2'b10) r_state <= S_CW3;
          else if (w_ab == 2'b01) r_state <= S_CW1;
          else if (w_ab == 2'b11) r_state <= S_REST;
        end
        S_CW3: begin
          if (w_ab == 2'b11) begin
            r_state   <= S_REST;
            r_step_up <= 1'b1;
            r_value   <= w_val_up;
          end else if (w_ab == 2'b00) begin
            r_state <= S_CW2;
          end
        end
        S_CCW1: begin
          if      (w_ab == 2'b00) r_state <= S_CCW2;
          else if (w_ab == 2'b11) r_state <= S_REST;
        end
        S_CCW2: begin
          if      (w_ab == 2'b01) r_state <= S_CCW3;
          else if (w_ab == 2'b10) r_state <= S_CCW1;
          else if (w_ab == 2'b11) r_state <= S_REST;
        end
        S_CCW3: begin
          if (w_ab == 2'b11) begin
            r_state   <= S_REST;
            r_step_dn <= 1'b1;
            r_value   <= w_val_dn;
          end else if (w_ab == 2'b00) begin
            r_state <= S_CCW2;
          end
        end
        default: r_state <= S_REST;
      endcase
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_press <= 1'b0;
      r_enable   <= 1'b1;
      r_pwm_cnt  <= '0;
      r_led      <= 1'b0;
    end else begin
      r_sw_press <= w_sw_fall;
      if (w_sw_fall) r_enable <= ~r_enable;
      r_pwm_cnt  <= r_pwm_cnt + VAL_W'(1);
      r_led      <= r_enable & (r_pwm_cnt < r_value);
    end
  end

  assign bus.value    = r_value;
  assign bus.step_up  = r_step_up;
  assign bus.step_dn  = r_step_dn;
  assign bus.sw_press = r_sw_press;
  assign bus.enable   = r_enable;
  assign bus.LED      = r_led;
endmodule
